// File: rtl/simple_gpio_input_ip.sv
// simple_gpio_input_ip
//
// Memory-mapped GPIO input peripheral. Each of WIDTH external pins passes
// through a two-flop synchronizer and a per-pin debounce filter. The debounced
// level is readable, and its rising/falling transitions set sticky
// write-one-to-clear flags. The flags, gated by per-edge enables, form one
// level interrupt.
//
// Ports
//   clk      system clock
//   resetn   asynchronous active-low reset
//   i_sel    chip select
//   i_we     write enable, qualified by i_sel
//   i_addr   word register select: 0 DATA, 1 RISE, 2 FALL, 3 IRQ_EN
//   i_wdata  write data from CPU
//   o_rdata  combinational read data for i_addr
//   i_gpio   external pins, asynchronous to clk
//   o_irq    level interrupt, active high
module simple_gpio_input_ip #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_sel,
   input  logic             i_we,
   input  logic [1:0]       i_addr,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata,
   input  logic [WIDTH-1:0] i_gpio,
   output logic             o_irq
);

   localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] level_nxt;
   logic [CNT_W-1:0] cnt     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;

   logic             wr;
   logic [WIDTH-1:0] rise_set;
   logic [WIDTH-1:0] fall_set;
   logic [WIDTH-1:0] rise_clr;
   logic [WIDTH-1:0] fall_clr;

   assign wr = i_sel && i_we;

   // Debounce: a pin must disagree with the accepted level for
   // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
   always_comb begin
      level_nxt = level;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (sync2[i] != level[i]) begin
            if (cnt[i] == CNT_MAX)
               level_nxt[i] = sync2[i];
            else
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
         end
      end
   end

   // Edges are taken from the level about to be accepted so the flag lands
   // on the same clock edge as the new DATA value.
   assign rise_set = level_nxt & ~level;
   assign fall_set = ~level_nxt & level;
   assign rise_clr = (wr && i_addr == 2'd1) ? i_wdata[WIDTH-1:0] : '0;
   assign fall_clr = (wr && i_addr == 2'd2) ? i_wdata[WIDTH-1:0] : '0;

   // Synchronizer stages sync1 -> sync2, then debounce state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1 <= '0;
         sync2 <= '0;
         level <= '0;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= '0;
      end else begin
         sync1 <= i_gpio;
         sync2 <= sync1;
         level <= level_nxt;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= cnt_nxt[i];
      end
   end

   // Sticky flags: OR-ing the set term after the clear makes a new edge win
   // over a simultaneous write-one-to-clear on the same bit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rise    <= '0;
         fall    <= '0;
         rise_en <= '0;
         fall_en <= '0;
      end else begin
         rise <= (rise & ~rise_clr) | rise_set;
         fall <= (fall & ~fall_clr) | fall_set;
         if (wr && i_addr == 2'd3) begin
            rise_en <= i_wdata[WIDTH-1:0];
            fall_en <= i_wdata[16 +: WIDTH];
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      case (i_addr)
         2'd0: o_rdata[WIDTH-1:0] = level;
         2'd1: o_rdata[WIDTH-1:0] = rise;
         2'd2: o_rdata[WIDTH-1:0] = fall;
         default: begin
            o_rdata[WIDTH-1:0]  = rise_en;
            o_rdata[16 +: WIDTH] = fall_en;
         end
      endcase
   end

   assign o_irq = (|(rise & rise_en)) | (|(fall & fall_en));

endmodule

// File: tb/tb_simple_gpio_input_ip.sv
`timescale 1ns/100ps
module tb_simple_gpio_input_ip;

   localparam int WIDTH = 4;
   localparam int DEB   = 16;

   logic             clk = 1'b0;
   logic             resetn;
   logic             i_sel;
   logic             i_we;
   logic [1:0]       i_addr;
   logic [31:0]      i_wdata;
   logic [31:0]      o_rdata;
   logic [WIDTH-1:0] i_gpio;
   logic             o_irq;

   int n_total = 0;
   int n_pass  = 0;

   string       tag_q [$];
   logic [1:0]  addr_q[$];
   logic [31:0] exp_q [$];

   simple_gpio_input_ip #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk    (clk),
      .resetn (resetn),
      .i_sel  (i_sel),
      .i_we   (i_we),
      .i_addr (i_addr),
      .i_wdata(i_wdata),
      .o_rdata(o_rdata),
      .i_gpio (i_gpio),
      .o_irq  (o_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h, required 0x%08h", tag, obs, exp);
   endtask

   // Expected register contents are queued as the stimulus is applied and
   // compared when the bus read is performed.
   task automatic expect_rd(input string tag, input logic [1:0] a, input logic [31:0] e);
      tag_q.push_back(tag);
      addr_q.push_back(a);
      exp_q.push_back(e);
   endtask

   // Called just after a falling edge; at most four entries fit before the
   // next rising edge.
   task automatic drain();
      while (exp_q.size() > 0) begin
         string       t;
         logic [1:0]  a;
         logic [31:0] e;
         t = tag_q.pop_front();
         a = addr_q.pop_front();
         e = exp_q.pop_front();
         i_addr = a;
         #1;
         chk(t, o_rdata, e);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one bus write; the write edge is the rising edge in between.
   task automatic bus_wr(input logic sel, input logic [1:0] a, input logic [31:0] d);
      i_sel   = sel;
      i_we    = 1'b1;
      i_addr  = a;
      i_wdata = d;
      @(negedge clk);
      i_sel   = 1'b0;
      i_we    = 1'b0;
      i_wdata = '0;
   endtask

   initial begin
      resetn  = 1'b0;
      i_sel   = 1'b0;
      i_we    = 1'b0;
      i_addr  = 2'd0;
      i_wdata = '0;
      i_gpio  = '0;

      // Reset state
      cycles(3);
      expect_rd("rst_data", 2'd0, 32'h0);
      expect_rd("rst_rise", 2'd1, 32'h0);
      expect_rd("rst_fall", 2'd2, 32'h0);
      expect_rd("rst_irqen", 2'd3, 32'h0);
      drain();
      chk("rst_irq", {31'b0, o_irq}, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      cycles(2);

      // 0x0 -> 0x5 settled before edge E: visible after E+17, not E+16
      i_gpio = 4'h5;
      cycles(DEB + 1);
      expect_rd("lat_data_early", 2'd0, 32'h0);
      expect_rd("lat_rise_early", 2'd1, 32'h0);
      drain();
      @(negedge clk);
      expect_rd("lat_data", 2'd0, 32'h5);
      expect_rd("lat_rise", 2'd1, 32'h5);
      drain();
      chk("lat_irq_disabled", {31'b0, o_irq}, 32'h0);

      // Register write masking and select qualification
      bus_wr(1'b1, 2'd3, 32'hFFFF_FFFF);
      expect_rd("irqen_mask", 2'd3, 32'h000F_000F);
      drain();
      chk("irq_enable_set_flag", {31'b0, o_irq}, 32'h1);
      bus_wr(1'b1, 2'd0, 32'hFFFF_FFFF);
      bus_wr(1'b0, 2'd3, 32'h0);
      bus_wr(1'b0, 2'd1, 32'hF);
      expect_rd("data_ro", 2'd0, 32'h5);
      expect_rd("irqen_nosel", 2'd3, 32'h000F_000F);
      expect_rd("rise_nosel", 2'd1, 32'h5);
      drain();
      bus_wr(1'b1, 2'd1, 32'h5);
      expect_rd("rise_w1c", 2'd1, 32'h0);
      drain();
      chk("irq_after_w1c", {31'b0, o_irq}, 32'h0);

      // Asynchronous reset with pin0 debounce in progress (cnt = 10)
      i_gpio = 4'h4;
      cycles(12);
      resetn = 1'b0;
      expect_rd("mid_rst_data", 2'd0, 32'h0);
      expect_rd("mid_rst_irqen", 2'd3, 32'h0);
      expect_rd("mid_rst_fall", 2'd2, 32'h0);
      drain();
      chk("mid_rst_irq", {31'b0, o_irq}, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      // pin2 held high through reset is accepted after the full delay
      cycles(DEB + 1);
      expect_rd("post_rst_data_early", 2'd0, 32'h0);
      drain();
      @(negedge clk);
      expect_rd("post_rst_data", 2'd0, 32'h4);
      expect_rd("post_rst_rise", 2'd1, 32'h4);
      drain();

      // Glitch of DEB-1 cycles on pin0 is rejected
      i_gpio = 4'h5;
      cycles(DEB - 1);
      i_gpio = 4'h4;
      cycles(20);
      expect_rd("glitch_data", 2'd0, 32'h4);
      expect_rd("glitch_rise", 2'd1, 32'h4);
      drain();
      bus_wr(1'b1, 2'd1, 32'h4);

      // DEB cycles on pin0 is accepted
      i_gpio = 4'h5;
      cycles(DEB);
      i_gpio = 4'h4;
      cycles(2);
      i_gpio = 4'h5;
      expect_rd("hold_data", 2'd0, 32'h5);
      expect_rd("hold_rise", 2'd1, 32'h1);
      drain();
      cycles(20);
      bus_wr(1'b1, 2'd1, 32'h1);

      // Falling edge interrupt
      bus_wr(1'b1, 2'd3, 32'h0001_0000);
      chk("fall_irq_idle", {31'b0, o_irq}, 32'h0);
      i_gpio = 4'h4;
      cycles(DEB + 1);
      expect_rd("fall_early", 2'd2, 32'h0);
      drain();
      chk("fall_irq_early", {31'b0, o_irq}, 32'h0);
      @(negedge clk);
      expect_rd("fall_flag", 2'd2, 32'h1);
      expect_rd("fall_data", 2'd0, 32'h4);
      drain();
      chk("fall_irq", {31'b0, o_irq}, 32'h1);
      bus_wr(1'b1, 2'd2, 32'h0);
      expect_rd("fall_w0", 2'd2, 32'h1);
      drain();
      chk("fall_irq_w0", {31'b0, o_irq}, 32'h1);
      bus_wr(1'b1, 2'd2, 32'h1);
      expect_rd("fall_w1c", 2'd2, 32'h0);
      drain();
      chk("fall_irq_cleared", {31'b0, o_irq}, 32'h0);

      // Set/clear collision: pin3 accepted on the same edge as RISE <= 0xF
      i_gpio = 4'h6;
      cycles(DEB + 4);
      expect_rd("coll_pre_rise", 2'd1, 32'h2);
      drain();
      i_gpio = 4'hE;
      cycles(DEB + 1);
      bus_wr(1'b1, 2'd1, 32'hF);
      expect_rd("coll_rise", 2'd1, 32'h8);
      expect_rd("coll_data", 2'd0, 32'hE);
      drain();
      chk("coll_irq", {31'b0, o_irq}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
